// File: rtl/ace_pkg.sv
// Shared ACE snoop-channel types and constants for the snoop port controller.
package ace_pkg;

  localparam int unsigned AcAddrWidth  = 64;
  localparam int unsigned AcSnoopWidth = 4;
  localparam int unsigned AcProtWidth  = 3;
  localparam int unsigned CrRespWidth  = 5;
  localparam int unsigned CdDataWidth  = 64;

  // CRRESP bit layout: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
  localparam int unsigned CrRespDataTransferBit = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AC   = 2'd1,
    CR   = 2'd2,
    CD   = 2'd3
  } snoop_state_e;

  typedef struct packed {
    logic [AcAddrWidth-1:0]  addr;
    logic [AcSnoopWidth-1:0] snoop;
    logic [AcProtWidth-1:0]  prot;
  } ac_chan_t;

  typedef logic [CrRespWidth-1:0] cr_chan_t;

  typedef struct packed {
    logic [CdDataWidth-1:0] data;
    logic                   last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_chan_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } ace_snoop_resp_t;

  // True when the snoop response announces that a CD data transfer follows.
  function automatic logic cr_has_data(input cr_chan_t resp);
    return resp[CrRespDataTransferBit];
  endfunction

endpackage

// File: rtl/ace_snoop_ac_reg.sv
// Load-enabled holding register for one snoop address beat. The controller
// only loads it while idle, so no spill/skid storage is needed.
module ace_snoop_ac_reg #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load,
  input  data_t value,
  output data_t held
);

  // Capture a new address beat when the controller accepts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held <= '0;
    end else if (load) begin
      held <= value;
    end
  end

endmodule

// File: rtl/ace_snoop_port_ctrl.sv
// Single-outstanding ACE snoop port controller sitting between the CCU and
// one cache. The address is re-launched from a holding register one cycle
// after acceptance; the response and data channels pass straight through
// while a beat counter polices the cache-line length of the CD burst.
module ace_snoop_port_ctrl
  import ace_pkg::*;
#(
  parameter int unsigned AxiDataWidth    = 64,
  parameter int unsigned DcacheLineWidth = 512,
  parameter int unsigned ErrCntWidth     = 8,
  parameter type         snoop_req_t     = ace_pkg::ace_snoop_req_t,
  parameter type         snoop_resp_t    = ace_pkg::ace_snoop_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  snoop_req_t             slv_req_i,
  output snoop_resp_t            slv_resp_o,
  output snoop_req_t             mst_req_o,
  input  snoop_resp_t            mst_resp_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  // A full cache line is moved as this many CD beats.
  localparam int unsigned Beats    = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned CntWidth = $clog2(Beats) + 1;
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(Beats - 1);

  snoop_state_e           state_q, state_d;
  logic [CntWidth-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ErrCntWidth-1:0] err_cnt_q;
  logic                   err_q;
  logic                   ac_load;
  ac_chan_t               held_ac;
  logic                   cd_fire;
  logic                   cd_at_end;
  logic                   cd_violation;

  ace_snoop_ac_reg #(
    .data_t (ac_chan_t)
  ) ace_snoop_ac_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (ac_load),
    .value (slv_req_i.ac),
    .held  (held_ac)
  );

  assign cd_fire   = mst_resp_i.cd_valid & slv_req_i.cd_ready;
  assign cd_at_end = (beat_cnt_q == LastBeat);

  // Next-state, beat counting and port muxing for the one snoop in flight.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    ac_load      = 1'b0;
    cd_violation = 1'b0;
    slv_resp_o   = '0;
    mst_req_o    = '0;
    mst_req_o.ac = held_ac;

    case (state_q)
      IDLE: begin
        // Ready is held low while reset is applied so nothing is accepted
        // until the controller is really running.
        slv_resp_o.ac_ready = ~rst_i;
        if (slv_req_i.ac_valid) begin
          ac_load = 1'b1;
          state_d = AC;
        end
      end

      AC: begin
        mst_req_o.ac_valid = 1'b1;
        if (mst_resp_i.ac_ready) begin
          state_d = CR;
        end
      end

      CR: begin
        slv_resp_o.cr_valid = mst_resp_i.cr_valid;
        slv_resp_o.cr_resp  = mst_resp_i.cr_resp;
        mst_req_o.cr_ready  = slv_req_i.cr_ready;
        if (mst_resp_i.cr_valid && slv_req_i.cr_ready) begin
          beat_cnt_d = '0;
          state_d    = cr_has_data(mst_resp_i.cr_resp) ? CD : IDLE;
        end
      end

      CD: begin
        slv_resp_o.cd_valid = mst_resp_i.cd_valid;
        slv_resp_o.cd       = mst_resp_i.cd;
        mst_req_o.cd_ready  = slv_req_i.cd_ready;
        if (cd_fire) begin
          if (mst_resp_i.cd.last || cd_at_end) begin
            // The burst ends either on LAST or on the expected final beat;
            // it is clean only when both coincide.
            cd_violation = mst_resp_i.cd.last ^ cd_at_end;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CntWidth'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Registered error pulse plus a saturating violation counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= cd_violation;
      if (cd_violation && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
      end
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule
